seq_booth_mult: RTL and testbench

Iterative radix-2 Booth multiplier that computes a 64-bit product of two 32-bit operands and produces the HI and LO words for the CPU's HI/LO architectural registers. It sits directly upstream of the two 32-bit HI/LO holding registers. Its `done` pulse drives their load inputs, and `hi`/`lo` drive their data inputs. It handles both signed and unsigned multiplies, selected per operation.

---
 rtl/seq_booth_mult.sv | 107 ++++++++++
 tb/tb_seq_booth_mult.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_booth_mult.sv
// Iterative radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// One Booth step per clock over WIDTH+1 steps; the result lands in hi/lo when entering DONE.
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold the last result
// RUN   | one Booth step per edge, then the edge that registers the product
// DONE  | single cycle with done=1, hi/lo valid
module seq_booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH:0]        m;
    logic [WIDTH:0]        acc;
    logic [WIDTH:0]        q;
    logic                  q_1;
    logic [CW-1:0]         count;
    logic [WIDTH:0]        sum;
    logic [2*WIDTH+1:0]    full;
    logic                  steps_done;

    assign steps_done = (count == LAST);
    assign full       = {acc, q};

    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (steps_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == DONE);
        done = (state == DONE);
    end

    always_comb begin
        case ({q[0], q_1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
    end

    // After WIDTH+1 steps the full signed product sits in {acc, q}; only its low 2*WIDTH bits matter.
    always_ff @(posedge clock) begin
        if (clear) begin
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= {signed_op & a[WIDTH-1], a};
                        q     <= {signed_op & b[WIDTH-1], b};
                        acc   <= '0;
                        q_1   <= 1'b0;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (!steps_done) begin
                        acc   <= {sum[WIDTH], sum[WIDTH:1]};
                        q     <= {sum[0], q[WIDTH:1]};
                        q_1   <= q[0];
                        count <= count + 1'b1;
                    end else begin
                        hi <= full[2*WIDTH-1:WIDTH];
                        lo <= full[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed bench for seq_booth_mult: vector table plus multi-cycle corner sequences.
module tb_seq_booth_mult;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    seq_booth_mult #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear), .start(start), .signed_op(signed_op),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called #1 after an edge while idle. Sample k is taken #1 after edge E_k, E0 = start edge.
    task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                          output logic [31:0] rh, output logic [31:0] rl,
                          output int lat, output int busy_n, output int done_n);
        a = va; b = vb; signed_op = vs; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom; signed_op = 1'($urandom);
        lat = -1; busy_n = 0; done_n = 0; rh = '0; rl = '0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat < 0) begin
                    lat = k;
                    rh = hi;
                    rl = lo;
                end
            end
            tick();
        end
    endtask

    initial begin
        logic [31:0] rh, rl, h1, l1;
        int lat, busy_n, done_n, gap, k;
        bit seen;

        vecs[0] = '{32'd7,        32'd6,        1'b0, 32'h00000000, 32'h0000002A};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001};
        vecs[3] = '{32'hFFFFFFFE, 32'd3,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
        vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
        vecs[6] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 32'hC0000000, 32'h80000000};
        vecs[7] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 32'h80000000};
        vecs[8] = '{32'h12345678, 32'h00000010, 1'b0, 32'h00000001, 32'h23456780};

        clear = 1'b1; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
        tick(); tick();
        clear = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi",   64'(hi),   64'd0);
        check("reset_lo",   64'(lo),   64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, rh, rl, lat, busy_n, done_n);
            check($sformatf("vec%0d_hi", i), 64'(rh), 64'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(rl), 64'(vecs[i].lo));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
            check($sformatf("vec%0d_done_count", i), 64'(done_n), 64'd1);
            check($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'd35);
        end

        // start held through the whole operation while operands churn
        a = 32'd3; b = 32'd4; signed_op = 1'b0; start = 1'b1;
        tick();
        done_n = 0; rh = '1; rl = '1;
        for (int j = 0; j < 60; j++) begin
            a = $urandom; b = $urandom; signed_op = 1'($urandom);
            if (done) begin
                done_n++;
                rh = hi; rl = lo;
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("held_start_done_count", 64'(done_n), 64'd1);
        check("held_start_hi", 64'(rh), 64'd0);
        check("held_start_lo", 64'(rl), 64'd12);
        check("held_start_idle", 64'(busy), 64'd0);

        // clear after RUN step 10 aborts the operation
        a = 32'd9; b = 32'd9; signed_op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi",   64'(hi),   64'd0);
        check("abort_lo",   64'(lo),   64'd0);
        done_n = 0;
        for (int j = 0; j < 40; j++) begin
            if (done || busy) done_n++;
            tick();
        end
        check("abort_no_activity", 64'(done_n), 64'd0);
        run_op(32'd5, 32'd5, 1'b0, rh, rl, lat, busy_n, done_n);
        check("after_abort_lo", 64'(rl), 64'h19);
        check("after_abort_hi", 64'(rh), 64'd0);
        check("after_abort_latency", 64'(lat), 64'd34);

        // back-to-back: second start in the first IDLE cycle after DONE
        a = 32'd3; b = 32'd3; signed_op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (k = 0; k < 60 && !seen; k++) begin
            if (done) seen = 1;
            else tick();
        end
        check("b2b_first_done_seen", 64'(seen), 64'd1);
        h1 = hi; l1 = lo;
        check("b2b_first_lo", 64'(l1), 64'd9);
        tick();
        check("b2b_idle_after_done", 64'(busy), 64'd0);
        a = 32'd4; b = 32'd4; signed_op = 1'b0; start = 1'b1;
        // gap counts edges from the DONE cycle: 1 to IDLE, 1 start edge, 34 latency = 36
        gap = 1;
        tick();
        gap++;
        start = 1'b0;
        a = $urandom; b = $urandom;
        seen = 0;
        rh = h1; rl = l1;
        for (int j = 0; j < 60 && !seen; j++) begin
            if (done) seen = 1;
            else begin
                if (hi !== h1 || lo !== l1) begin rh = hi; rl = lo; end
                tick();
                gap++;
            end
        end
        check("b2b_second_done_seen", 64'(seen), 64'd1);
        check("b2b_gap", 64'(gap), 64'd36);
        check("b2b_hold_hi", 64'(rh), 64'(h1));
        check("b2b_hold_lo", 64'(rl), 64'(l1));
        check("b2b_second_lo", 64'(lo), 64'd16);
        tick();
        check("b2b_done_single", 64'(done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
